// File: rtl/bcd_convert_sched.sv
// rtl/bcd_convert_sched.sv - shared sequential binary-to-BCD engine with two-port round-robin scheduler
module bcd_convert_sched #(
    parameter int WIDTH      = 32,
    parameter int INT_DIGITS = 10,
    parameter int OUT_DIGITS = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req0,
    input  logic [WIDTH-1:0]        data0,
    output logic                    gnt0,
    input  logic                    req1,
    input  logic [WIDTH-1:0]        data1,
    output logic                    gnt1,
    output logic                    busy,
    output logic                    done,
    output logic                    done_id,
    output logic [4*OUT_DIGITS-1:0] bcd_out,
    output logic                    ovf
);

    localparam int ACC_W = 4 * INT_DIGITS;
    localparam int OUT_W = 4 * OUT_DIGITS;
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sh_q, sh_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   acc_adj;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ptr_q, ptr_d;
    logic               id_q, id_d;
    logic               pick;
    logic               gnt0_q, gnt0_d;
    logic               gnt1_q, gnt1_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               done_id_q, done_id_d;
    logic [OUT_W-1:0]   bcd_q, bcd_d;
    logic               ovf_q, ovf_d;

    // Add-3 correction: each digit 5..9 becomes 8..12, no carry into the next digit
    always_comb begin
        acc_adj = acc_q;
        for (int i = 0; i < INT_DIGITS; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) begin
                acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Round-robin pick: a lone requester wins, on contention the pointer decides
    always_comb begin
        pick = 1'b0;
        if (req0 && req1) begin
            pick = ptr_q;
        end else if (req1) begin
            pick = 1'b1;
        end
    end

    // Next-state logic for the scheduler / double-dabble sequencer
    always_comb begin
        state_d   = state_q;
        sh_d      = sh_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        id_d      = id_q;
        gnt0_d    = 1'b0;
        gnt1_d    = 1'b0;
        busy_d    = busy_q;
        done_d    = 1'b0;
        done_id_d = done_id_q;
        bcd_d     = bcd_q;
        ovf_d     = ovf_q;
        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (req0 || req1) begin
                    id_d    = pick;
                    ptr_d   = ~pick;
                    sh_d    = pick ? data1 : data0;
                    acc_d   = '0;
                    cnt_d   = '0;
                    gnt0_d  = ~pick;
                    gnt1_d  = pick;
                    busy_d  = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                {acc_d, sh_d} = {acc_adj, sh_q} << 1;
                cnt_d         = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                bcd_d     = acc_q[OUT_W-1:0];
                ovf_d     = |(acc_q >> OUT_W);
                done_id_d = id_q;
                done_d    = 1'b1;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset discards any in-flight conversion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            sh_q      <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            ptr_q     <= 1'b0;
            id_q      <= 1'b0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= 1'b0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sh_q      <= sh_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            id_q      <= id_d;
            gnt0_q    <= gnt0_d;
            gnt1_q    <= gnt1_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            bcd_q     <= bcd_d;
            ovf_q     <= ovf_d;
        end
    end

    assign gnt0    = gnt0_q;
    assign gnt1    = gnt1_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign done_id = done_id_q;
    assign bcd_out = bcd_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_bcd_convert_sched.sv
// tb/tb_bcd_convert_sched.sv - scoreboard bench for bcd_convert_sched
module tb_bcd_convert_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0 = 1'b0;
    logic [31:0] data0 = '0;
    logic        gnt0;
    logic        req1 = 1'b0;
    logic [31:0] data1 = '0;
    logic        gnt1;
    logic        busy;
    logic        done;
    logic        done_id;
    logic [31:0] bcd_out;
    logic        ovf;

    typedef struct {
        logic        id;
        logic [31:0] bcd;
        logic        ovf;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   gnt_cyc  = 0;
    logic prev_busy = 1'b0;
    logic prev_done = 1'b0;

    bcd_convert_sched dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req0    (req0),
        .data0   (data0),
        .gnt0    (gnt0),
        .req1    (req1),
        .data1   (data1),
        .gnt1    (gnt1),
        .busy    (busy),
        .done    (done),
        .done_id (done_id),
        .bcd_out (bcd_out),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic id, input logic [31:0] v);
        exp_t        e;
        logic [63:0] x;
        x     = {32'd0, v};
        e.id  = id;
        e.bcd = '0;
        for (int k = 0; k < 8; k++) begin
            e.bcd[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        e.ovf = (x != 0);
        return e;
    endfunction

    // Scoreboard: push on grant, pop and compare on done
    always @(negedge clk) begin
        if (rst_n) begin
            if (gnt0 || gnt1) begin
                check("gnt_exclusive", {63'd0, gnt0 & gnt1}, 64'd0);
                check("gnt_while_busy", {63'd0, prev_busy & ~prev_done}, 64'd0);
                exp_q.push_back(model(gnt1, gnt1 ? data1 : data0));
                gnt_cyc = cyc;
            end
            if (done) begin
                check("sb_underflow", {63'd0, exp_q.size() == 0}, 64'd0);
                if (exp_q.size() != 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("bcd_out", {32'd0, bcd_out}, {32'd0, e.bcd});
                    check("ovf", {63'd0, ovf}, {63'd0, e.ovf});
                    check("done_id", {63'd0, done_id}, {63'd0, e.id});
                    check("latency", 64'(cyc - gnt_cyc), 64'd33);
                end
            end
        end
        prev_busy = busy;
        prev_done = done;
    end

    task automatic wait_gnt(output logic got);
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (gnt0 || gnt1) begin
                got = 1'b1;
                break;
            end
        end
        check("gnt_timeout", {63'd0, got}, 64'd1);
    endtask

    task automatic wait_done();
        logic got;
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        check("done_timeout", {63'd0, got}, 64'd1);
    endtask

    task automatic conv(input logic id, input logic [31:0] v);
        logic got;
        @(negedge clk);
        if (id) begin
            data1 = v;
            req1  = 1'b1;
        end else begin
            data0 = v;
            req0  = 1'b1;
        end
        wait_gnt(got);
        req0 = 1'b0;
        req1 = 1'b0;
        wait_done();
    endtask

    initial begin
        logic got;
        int   last_cyc;

        repeat (3) @(negedge clk);
        check("rst_gnt0", {63'd0, gnt0}, 64'd0);
        check("rst_gnt1", {63'd0, gnt1}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_bcd", {32'd0, bcd_out}, 64'd0);
        check("rst_ovf", {63'd0, ovf}, 64'd0);
        rst_n = 1'b1;

        conv(1'b0, 32'd0);
        conv(1'b1, 32'd12345678);
        conv(1'b0, 32'd99999999);
        conv(1'b0, 32'd100000000);
        conv(1'b0, 32'd4294967295);
        conv(1'b1, 32'd87654321);

        // Data change after grant, plus a request arriving mid-conversion
        @(negedge clk);
        data0 = 32'd55;
        req0  = 1'b1;
        wait_gnt(got);
        req0 = 1'b0;
        @(negedge clk);
        data0 = 32'd7;
        check("busy_in_shift", {63'd0, busy}, 64'd1);
        repeat (5) @(negedge clk);
        data1 = 32'd321;
        req1  = 1'b1;
        wait_done();
        @(negedge clk);
        check("gnt1_first_idle", {63'd0, gnt1}, 64'd1);
        req1 = 1'b0;
        wait_done();

        // Both held: grants alternate every 34 cycles
        @(negedge clk);
        data0 = 32'd1;
        data1 = 32'd2;
        req0  = 1'b1;
        req1  = 1'b1;
        last_cyc = 0;
        for (int g = 0; g < 4; g++) begin
            wait_gnt(got);
            check("rr_order", {63'd0, gnt1}, 64'(g % 2));
            if (g > 0) check("rr_interval", 64'(cyc - last_cyc), 64'd34);
            last_cyc = cyc;
        end
        req0 = 1'b0;
        req1 = 1'b0;
        wait_done();

        // Reset mid-shift after a port-0 grant, pointer must return to port 0
        @(negedge clk);
        data0 = 32'd4321;
        req0  = 1'b1;
        wait_gnt(got);
        req0 = 1'b0;
        repeat (15) @(negedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("arst_busy", {63'd0, busy}, 64'd0);
        check("arst_done", {63'd0, done}, 64'd0);
        check("arst_bcd", {32'd0, bcd_out}, 64'd0);
        check("arst_id", {63'd0, done_id}, 64'd0);
        data0 = 32'd5;
        data1 = 32'd6;
        req0  = 1'b1;
        req1  = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_gnt(got);
        check("post_rst_gnt0", {63'd0, gnt0}, 64'd1);
        req0 = 1'b0;
        wait_gnt(got);
        check("post_rst_gnt1", {63'd0, gnt1}, 64'd1);
        req1 = 1'b0;
        wait_done();
        repeat (3) @(negedge clk);
        check("sb_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_convert_sched.md
Name: bcd_convert_sched

Overview:
- Shared, multi-cycle binary-to-BCD conversion engine with a built-in two-requester round-robin scheduler.
- Replaces per-consumer combinational divide/modulo conversion, which is too slow and large to instantiate several times.
- Typical requesters: register-file debug tap (port 0) and PC/cycle-count display (port 1).
- Sequential double-dabble (shift-add-3), one input bit per cycle; the result feeds the seven-segment digit drivers.

Parameters:
- WIDTH, 32, binary input width.
- INT_DIGITS, 10, internal BCD digits; must be >= ceil(WIDTH*log10(2)).
- OUT_DIGITS, 8, BCD digits presented on bcd_out; must be <= INT_DIGITS.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0  in  1  requester 0 conversion request; level, held until gnt0.
- data0  in  WIDTH  requester 0 binary value; stable while req0 high.
- gnt0  out  1  one-cycle pulse: data0 captured.
- req1  in  1  requester 1 request; same rules as req0.
- data1  in  WIDTH  requester 1 binary value.
- gnt1  out  1  one-cycle pulse: data1 captured.
- busy  out  1  high from grant until done, inclusive.
- done  out  1  one-cycle pulse: bcd_out/ovf/done_id updated.
- done_id  out  1  requester index of the completed conversion.
- bcd_out  out  4*OUT_DIGITS  packed digits; digit0 (ones) at [3:0], digit k at [4k+3:4k].
- ovf  out  1  value >= 10^OUT_DIGITS, so upper digits are truncated.

Behaviour:
- Reset (async assert, sync to clk on deassert by system):
  - gnt0, gnt1, busy, done, done_id, ovf = 0; bcd_out = 0.
  - FSM -> IDLE; round-robin pointer favours requester 0.
  - Any in-flight conversion is discarded; no done is produced.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - No request: stay.
  - Otherwise grant one requester at edge E0: latch its data into shift register; clear INT_DIGITS BCD accumulator and bit counter; pulse gnt for the cycle after E0; busy=1; go SHIFT.
- Arbitration:
  - Only one request: grant it.
  - Both requesting: grant the requester not granted last; pointer updates on every grant.
- SHIFT, edges E1..E_WIDTH:
  - Each edge, every accumulator digit >= 5 gets +3.
  - Then the {accumulator, shift register} concatenation shifts left by 1 (MSB of data first).
  - Counter increments; at the last shift (counter == WIDTH-1) go DONE.
- DONE, edge E_WIDTH+1:
  - bcd_out = lower OUT_DIGITS accumulator digits.
  - ovf = OR of all upper digits being non-zero.
  - done_id = granted index; done pulses for one cycle; busy drops with that cycle; go IDLE.
- Timing and holds:
  - Latency grant edge -> done = WIDTH+1 cycles (33 at default).
  - bcd_out/ovf/done_id hold until the next done.
- Throughput: requests are sampled only in IDLE. A request held continuously is granted at edge E_WIDTH+2, so back-to-back conversions run every WIDTH+2 cycles (34).
- Requests asserted during SHIFT/DONE wait; never lost, never granted early.
- gnt0 and gnt1 are never high together. gnt is never issued while busy is already high from a prior grant.
- Arithmetic:
  - All digit add-3 corrections operate on 4-bit values 5..9 only.
  - No carry between digits is generated by the correction.
  - Result digits are always 0..9.
- Data changes after gnt do not affect the in-flight conversion.

Test Plan:
- Reset, then req0 with data0=0: gnt0 at E0+1; done 33 cycles later; bcd_out=0x00000000, ovf=0, done_id=0.
- req1 with data1=12345678: bcd_out=0x12345678, ovf=0, done_id=1.
- data0=99999999 gives bcd_out=0x99999999, ovf=0. data0=100000000 gives 0x00000000, ovf=1. data0=4294967295 gives 0x94967295, ovf=1.
- req0 and req1 high together and held, data0=1, data1=2:
  - Grants alternate 0,1,0,… every 34 cycles.
  - bcd_out alternates 0x00000001/0x00000002 with matching done_id.
- rst_n pulsed low at SHIFT cycle 15:
  - All outputs 0 immediately (async).
  - No done is produced.
  - After release, a pending req1 is still granted only after req0 priority is re-established (req0 wins if both high).
- Change data0 to 7 the cycle after gnt0 (original 55): result 0x00000055. Requester 1 asserting during busy is granted exactly at the first IDLE edge.
